// File: rtl/conv_job_scheduler_if.sv
// conv_job_scheduler_if: host job-push channel plus control-unit start/config channel.
// The host (or bench) drives the master side; the scheduler is the slave.
interface conv_job_scheduler_if #(parameter int AW = 16);
   logic          job_valid;
   logic          job_ready;
   logic [1:0]    job_mode;
   logic [AW-1:0] job_if_addr;
   logic [AW-1:0] job_filt_addr;
   logic [AW-1:0] job_psum_addr;
   logic          cu_start;
   logic [1:0]    cu_mode;
   logic [AW-1:0] cu_if_base;
   logic [AW-1:0] cu_filt_base;
   logic [AW-1:0] cu_psum_base;
   logic          cu_ready;
   logic          cu_done;
   modport master (
      output job_valid, job_mode, job_if_addr, job_filt_addr, job_psum_addr, cu_ready, cu_done,
      input  job_ready, cu_start, cu_mode, cu_if_base, cu_filt_base, cu_psum_base
   );
   modport slave (
      input  job_valid, job_mode, job_if_addr, job_filt_addr, job_psum_addr, cu_ready, cu_done,
      output job_ready, cu_start, cu_mode, cu_if_base, cu_filt_base, cu_psum_base
   );
endinterface

// File: rtl/conv_job_scheduler.sv
// conv_job_scheduler: queues conv jobs and issues them one at a time to the control unit with a watchdog.
// Optional JOB_CYCLE_CNT_EN adds last_job_cycles (cycles from pop to done of the last retired job).
module conv_job_scheduler #(
   parameter int AW        = 16,
   parameter int DEPTH     = 4,
   parameter int START_CYC = 2,
   parameter int TIMEOUT   = 4096,
   parameter int CW        = 16
) (
   input  logic          clk,
   input  logic          rst,
   conv_job_scheduler_if.slave bus,
   output logic          busy,
   output logic [CW-1:0] jobs_done,
   output logic [CW-1:0] rej_cnt,
   output logic          timeout_err
`ifdef JOB_CYCLE_CNT_EN
   ,
   output logic [CW-1:0] last_job_cycles
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int SW = $clog2(START_CYC + 1);
   localparam int WW = $clog2(TIMEOUT);
   typedef struct packed {
      logic [1:0]    mode;
      logic [AW-1:0] ifa;
      logic [AW-1:0] filt;
      logic [AW-1:0] psum;
   } job_t;
   typedef enum logic [1:0] {IDLE, START_HI, START_LO, RUN} state_t;
   state_t        state_q, state_d;
   job_t          mem_q [DEPTH];
   job_t          mem_d [DEPTH];
   job_t          act_q, act_d;
   logic [PW:0]   wp_q, wp_d, rp_q, rp_d;
   logic [SW-1:0] sc_q, sc_d;
   logic [WW-1:0] wd_q, wd_d;
   logic [CW-1:0] done_q, done_d, rej_q, rej_d;
   logic          terr_q, terr_d;
   logic          full, empty, push, pop;
   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full  = (wp_q ^ rp_q) == {1'b1, {PW{1'b0}}};
   assign empty = wp_q == rp_q;
   assign bus.job_ready = !rst && !full;
   assign push  = bus.job_valid && bus.job_ready;
   assign pop   = state_q == IDLE && !empty;
   always_comb begin
      mem_d   = mem_q;
      wp_d    = wp_q;
      rp_d    = rp_q;
      state_d = state_q;
      act_d   = act_q;
      sc_d    = sc_q;
      wd_d    = wd_q;
      done_d  = done_q;
      terr_d  = 1'b0;
      rej_d   = (push && bus.job_mode == 2'd0 && !(&rej_q)) ? rej_q + 1'b1 : rej_q;
      if (push && bus.job_mode != 2'd0) begin
         mem_d[wp_q[PW-1:0]] = {bus.job_mode, bus.job_if_addr, bus.job_filt_addr, bus.job_psum_addr};
         wp_d = wp_q + 1'b1;
      end
      case (state_q)
         IDLE: if (pop) begin
            act_d   = mem_q[rp_q[PW-1:0]];
            rp_d    = rp_q + 1'b1;
            sc_d    = SW'(START_CYC - 1);
            state_d = START_HI;
         end
         START_HI: if (sc_q == '0) begin
            state_d = START_LO;
            wd_d    = '0;
         end else sc_d = sc_q - 1'b1;
         START_LO, RUN: begin
            wd_d = wd_q + 1'b1;
            // A done pulse in the expiry cycle still retires the job.
            if (state_q == RUN && bus.cu_done) begin
               done_d  = done_q + 1'b1;
               state_d = IDLE;
            end else if (wd_q == WW'(TIMEOUT - 1)) begin
               terr_d  = 1'b1;
               state_d = IDLE;
            end else if (state_q == START_LO && bus.cu_ready) state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         mem_q   <= '{default: '0};
         act_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         sc_q    <= '0;
         wd_q    <= '0;
         done_q  <= '0;
         rej_q   <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mem_q   <= mem_d;
         act_q   <= act_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         sc_q    <= sc_d;
         wd_q    <= wd_d;
         done_q  <= done_d;
         rej_q   <= rej_d;
         terr_q  <= terr_d;
      end
   end
   assign bus.cu_start     = state_q == START_HI;
   assign bus.cu_mode      = act_q.mode;
   assign bus.cu_if_base   = act_q.ifa;
   assign bus.cu_filt_base = act_q.filt;
   assign bus.cu_psum_base = act_q.psum;
   assign busy             = state_q != IDLE || !empty;
   assign jobs_done        = done_q;
   assign rej_cnt          = rej_q;
   assign timeout_err      = terr_q;
`ifdef JOB_CYCLE_CNT_EN
   logic [CW-1:0] cyc_q, cyc_d, lc_q, lc_d;
   always_comb begin
      cyc_d = pop ? '0 : (&cyc_q) ? cyc_q : cyc_q + 1'b1;
      lc_d  = (state_q == RUN && bus.cu_done) ? cyc_q : lc_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cyc_q <= '0;
         lc_q  <= '0;
      end else begin
         cyc_q <= cyc_d;
         lc_q  <= lc_d;
      end
   end
   assign last_job_cycles = lc_q;
`endif
endmodule

// File: tb/tb_conv_job_scheduler.sv
// tb_conv_job_scheduler: directed scenarios plus random traffic, checked every cycle against a
// job-level model (queue of jobs, age of the active job since its pop).
module tb_conv_job_scheduler;
   localparam int AW = 16, DEPTH = 4, SC = 2, TO = 16, CW = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic busy, timeout_err;
   logic [CW-1:0] jobs_done, rej_cnt;
`ifdef JOB_CYCLE_CNT_EN
   logic [CW-1:0] last_job_cycles;
`endif
   always #5 clk = ~clk;
   conv_job_scheduler_if #(.AW(AW)) bus();
   conv_job_scheduler #(.AW(AW), .DEPTH(DEPTH), .START_CYC(SC), .TIMEOUT(TO), .CW(CW)) dut (
      .clk(clk), .rst(rst), .bus(bus), .busy(busy), .jobs_done(jobs_done),
      .rej_cnt(rej_cnt), .timeout_err(timeout_err)
`ifdef JOB_CYCLE_CNT_EN
      , .last_job_cycles(last_job_cycles)
`endif
   );
   typedef struct packed {
      logic [1:0]    m;
      logic [AW-1:0] a, f, p;
   } job_t;
   job_t q[$];
   job_t cur;
   bit   act, ran, m_terr, chk_en;
   int   age, m_done, m_rej, checks, fails, cyc;
   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, a, e);
      end
   endtask
   task automatic tick();
      @(negedge clk);
      #1;
   endtask
   always @(posedge clk) cyc++;
   // Model: age counts cycles since the pop; start is high for ages 1..SC, then the watchdog age is age-SC-1.
   always @(posedge clk) begin
      bit rdy;
      job_t j;
      rdy = !rst && q.size() < DEPTH;
      if (rst) begin
         q.delete();
         act = 0; ran = 0; age = 0; cur = '0; m_done = 0; m_rej = 0; m_terr = 0;
      end else begin
         m_terr = 0;
         if (act) begin
            if (age <= SC) age++;
            else begin
               int w;
               w = age - SC - 1;
               if (ran && bus.cu_done) begin
                  act = 0;
                  m_done = (m_done + 1) % (1 << CW);
               end else if (w == TO - 1) begin
                  act = 0;
                  m_terr = 1;
               end else begin
                  if (bus.cu_ready) ran = 1;
                  age++;
               end
            end
         end else if (q.size() > 0) begin
            cur = q.pop_front();
            act = 1; age = 1; ran = 0;
         end
         if (bus.job_valid && rdy) begin
            if (bus.job_mode == 2'd0) begin
               if (m_rej < (1 << CW) - 1) m_rej++;
            end else begin
               j.m = bus.job_mode; j.a = bus.job_if_addr; j.f = bus.job_filt_addr; j.p = bus.job_psum_addr;
               q.push_back(j);
            end
         end
      end
   end
   always @(negedge clk) if (chk_en) begin
      chk("job_ready", bus.job_ready, !rst && q.size() < DEPTH);
      chk("cu_start", bus.cu_start, act && age <= SC);
      chk("cu_mode", bus.cu_mode, cur.m);
      chk("cu_if_base", bus.cu_if_base, cur.a);
      chk("cu_filt_base", bus.cu_filt_base, cur.f);
      chk("cu_psum_base", bus.cu_psum_base, cur.p);
      chk("busy", busy, act || q.size() > 0);
      chk("jobs_done", jobs_done, m_done);
      chk("rej_cnt", rej_cnt, m_rej);
      chk("timeout_err", timeout_err, m_terr);
   end
   task automatic push(input logic [1:0] m, input logic [AW-1:0] a, f, p);
      bus.job_mode = m; bus.job_if_addr = a; bus.job_filt_addr = f; bus.job_psum_addr = p;
      bus.job_valid = 1'b1;
      tick();
      bus.job_valid = 1'b0;
   endtask
   task automatic wait_lo();
      bit seen = 0;
      for (int i = 0; i < 100 && !(seen && !bus.cu_start); i++) begin
         seen |= bus.cu_start;
         tick();
      end
      chk("start_fall_seen", seen && !bus.cu_start, 1);
   endtask
   initial begin
      int n, acc, t0;
      bus.job_valid = 0; bus.job_mode = 0; bus.job_if_addr = 0; bus.job_filt_addr = 0;
      bus.job_psum_addr = 0; bus.cu_ready = 0; bus.cu_done = 0;
      @(posedge clk);
      chk_en = 1;
      tick();
      chk("ready_in_rst", bus.job_ready, 0);
      chk("busy_in_rst", busy, 0);
      rst = 0;
      push(2'd2, 16'h0010, 16'h0200, 16'h0800);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (bus.cu_start) n++;
         else if (n > 0) break;
         tick();
      end
      chk("t1_start_cycles", n, 2);
      chk("t1_mode", bus.cu_mode, 2);
      bus.cu_ready = 1;
      tick();
      bus.cu_ready = 0;
      repeat (9) tick();
      bus.cu_done = 1;
      tick();
      bus.cu_done = 0;
      chk("t1_jobs_done", jobs_done, 1);
      chk("t1_busy", busy, 0);
      chk("t1_if", bus.cu_if_base, 16'h0010);
      chk("t1_filt", bus.cu_filt_base, 16'h0200);
      chk("t1_psum", bus.cu_psum_base, 16'h0800);
      push(2'd0, 16'h1, 16'h2, 16'h3);
      chk("t3_rej", rej_cnt, 1);
      chk("t3_busy", busy, 0);
      acc = 0;
      bus.job_valid = 1;
      for (int i = 0; i < 12; i++) begin
         bus.job_mode = 2'(1 + acc % 3);
         bus.job_if_addr = 16'(acc); bus.job_filt_addr = 16'(acc + 100); bus.job_psum_addr = 16'(acc + 200);
         if (bus.job_ready) acc++;
         tick();
      end
      bus.job_valid = 0;
      chk("t2_accepted", acc, 5);
      chk("t2_ready_low", bus.job_ready, 0);
      chk("t2_active_mode", bus.cu_mode, 1);
      for (int i = 0; i < 100 && !timeout_err; i++) tick();
      chk("t4_first_timeout", timeout_err, 1);
      chk("t4_done_kept", jobs_done, 1);
      wait_lo();
      t0 = cyc;
      for (int i = 0; i < 40 && !timeout_err; i++) tick();
      chk("t4_timeout_seen", timeout_err, 1);
      chk("t4_timeout_delay", cyc - t0, 16);
      tick();
      chk("t4_single_pulse", timeout_err, 0);
      chk("t4_done_unchanged", jobs_done, 1);
      wait_lo();
      bus.cu_ready = 1;
      tick();
      bus.cu_ready = 0;
      repeat (14) tick();
      bus.cu_done = 1;
      bus.job_mode = 2'd3; bus.job_if_addr = 16'h0abc; bus.job_valid = 1;
      tick();
      bus.cu_done = 0; bus.job_valid = 0;
      chk("t5_done_wins", jobs_done, 2);
      chk("t5_no_timeout", timeout_err, 0);
      wait_lo();
      bus.cu_ready = 1;
      tick();
      bus.cu_ready = 0;
      tick();
      rst = 1;
      tick();
      rst = 0;
      chk("t6_busy", busy, 0);
      chk("t6_jobs_done", jobs_done, 0);
      chk("t6_mode", bus.cu_mode, 0);
      n = 0;
      repeat (10) begin
         tick();
         n += int'(bus.cu_start);
      end
      chk("t6_no_start", n, 0);
      chk("t6_busy_after", busy, 0);
      for (int i = 0; i < 4000; i++) begin
         rst = ($urandom_range(0, 999) == 0);
         bus.job_valid = ($urandom_range(0, 3) == 0);
         bus.job_mode = 2'($urandom_range(0, 3));
         bus.job_if_addr = 16'($urandom); bus.job_filt_addr = 16'($urandom); bus.job_psum_addr = 16'($urandom);
         bus.cu_ready = ($urandom_range(0, 3) == 0);
         bus.cu_done = ($urandom_range(0, 19) == 0);
         tick();
      end
      rst = 0; bus.job_valid = 0; bus.cu_ready = 0; bus.cu_done = 0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
